// File: rtl/dpwm_gen_if.sv
// rtl/dpwm_gen_if.sv - duty command in, gate drives and strobes out of the modulator
interface dpwm_gen_if;
  logic       en;
  logic [8:0] d_comp;
  logic       pwm_hs;
  logic       pwm_ls;
  logic       adc_trig;
  logic       prd_strb;
  logic [8:0] duty_o;

  modport slave (
    input  en, d_comp,
    output pwm_hs, pwm_ls, adc_trig, prd_strb, duty_o
  );

  modport master (
    output en, d_comp,
    input  pwm_hs, pwm_ls, adc_trig, prd_strb, duty_o
  );
endinterface

// File: rtl/dpwm_gen.sv
// rtl/dpwm_gen.sv - 512-cycle digital PWM with dead-time, duty clamp and ADC/period strobes
module dpwm_gen #(
  parameter int DT       = 4,
  parameter int DUTY_MAX = 486
) (
  input  logic        clk,
  input  logic        rst,
  dpwm_gen_if.slave   bus
);
  localparam logic [8:0] DT_C       = 9'(DT);
  localparam logic [8:0] DUTY_MAX_C = 9'(DUTY_MAX);
  localparam logic [8:0] CNT_LAST   = 9'd511;

  logic [8:0] cnt;
  logic [8:0] duty_act;
  logic [8:0] duty_cmd;
  logic [9:0] ls_start;
  logic       hs_next;
  logic       ls_next;
  logic       adc_next;
  logic       prd_next;

  logic       pwm_hs_q;
  logic       pwm_ls_q;
  logic       adc_trig_q;
  logic       prd_strb_q;

  always_comb begin
    duty_cmd = (bus.d_comp > DUTY_MAX_C) ? DUTY_MAX_C : bus.d_comp;
    // 10-bit sum so a large duty plus dead-time never wraps into a low-side pulse
    ls_start = {1'b0, duty_act} + {1'b0, DT_C};
    hs_next  = (cnt >= DT_C) && (cnt < duty_act);
    ls_next  = ({1'b0, cnt} >= ls_start);
    adc_next = (cnt == (duty_act >> 1));
    prd_next = (cnt == 9'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 9'd0;
      duty_act   <= 9'd0;
      pwm_hs_q   <= 1'b0;
      pwm_ls_q   <= 1'b0;
      adc_trig_q <= 1'b0;
      prd_strb_q <= 1'b0;
    end else if (!bus.en) begin
      cnt        <= 9'd0;
      duty_act   <= duty_cmd;
      pwm_hs_q   <= 1'b0;
      pwm_ls_q   <= 1'b0;
      adc_trig_q <= 1'b0;
      prd_strb_q <= 1'b0;
    end else begin
      cnt <= cnt + 9'd1;
      // duty only changes on the period boundary so a period is never torn
      if (cnt == CNT_LAST) begin
        duty_act <= duty_cmd;
      end
      pwm_hs_q   <= hs_next;
      pwm_ls_q   <= ls_next;
      adc_trig_q <= adc_next;
      prd_strb_q <= prd_next;
    end
  end

  assign bus.pwm_hs   = pwm_hs_q;
  assign bus.pwm_ls   = pwm_ls_q;
  assign bus.adc_trig = adc_trig_q;
  assign bus.prd_strb = prd_strb_q;
  assign bus.duty_o   = duty_act;
endmodule

// File: tb/tb_dpwm_gen.sv
// tb/tb_dpwm_gen.sv - bench for dpwm_gen at DT 0, 4 and 15 against a rule-level model
module tb_dpwm_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [8:0] d_comp;

  always #5 clk = ~clk;

  dpwm_gen_if if0();
  dpwm_gen_if if1();
  dpwm_gen_if if2();

  assign if0.en = en;
  assign if0.d_comp = d_comp;
  assign if1.en = en;
  assign if1.d_comp = d_comp;
  assign if2.en = en;
  assign if2.d_comp = d_comp;

  dpwm_gen #(.DT(0),  .DUTY_MAX(486)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  dpwm_gen #(.DT(4),  .DUTY_MAX(486)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  dpwm_gen #(.DT(15), .DUTY_MAX(486)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dt_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 4 : 15;
  endfunction

  function automatic int clampd(input int d);
    return (d > 486) ? 486 : d;
  endfunction

  // Output rules for counter position c and applied duty d: {hs, ls, adc, prd}
  function automatic logic [3:0] rule(input int dt, input int c, input int d);
    logic hs, ls, adc, prd;
    hs  = (c >= dt) && (c < d);
    ls  = (c >= d + dt);
    adc = (c == d / 2);
    prd = (c == 0);
    return {hs, ls, adc, prd};
  endfunction

  int         m_cnt = 0;
  int         m_duty = 0;
  logic [3:0] exp_o [3];
  bit         exp_act = 0;
  bit         model_ready = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      exp_o[k] <= (rst || !en) ? 4'b0000 : rule(dt_of(k), m_cnt, m_duty);
    exp_act <= !rst && en;
    if (rst) begin
      m_cnt  <= 0;
      m_duty <= 0;
    end else if (!en) begin
      m_cnt  <= 0;
      m_duty <= clampd(int'(d_comp));
    end else begin
      if (m_cnt == 511) m_duty <= clampd(int'(d_comp));
      m_cnt <= (m_cnt + 1) % 512;
    end
    model_ready <= 1'b1;
  end

  int per_len [3] = '{0, 0, 0};
  int adc_seen[3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (model_ready) begin
      for (int k = 0; k < 3; k++) begin
        logic [3:0] act;
        int         duty;
        case (k)
          0: begin act = {if0.pwm_hs, if0.pwm_ls, if0.adc_trig, if0.prd_strb}; duty = int'(if0.duty_o); end
          1: begin act = {if1.pwm_hs, if1.pwm_ls, if1.adc_trig, if1.prd_strb}; duty = int'(if1.duty_o); end
          default: begin act = {if2.pwm_hs, if2.pwm_ls, if2.adc_trig, if2.prd_strb}; duty = int'(if2.duty_o); end
        endcase
        chk($sformatf("outs_dt%0d", dt_of(k)), int'(act), int'(exp_o[k]));
        chk($sformatf("duty_o_dt%0d", dt_of(k)), duty, m_duty);
        chk($sformatf("overlap_dt%0d", dt_of(k)), int'(act[3] & act[2]), 0);
        if (duty > 486) chk($sformatf("duty_max_dt%0d", dt_of(k)), duty, 486);
        if (act[0]) begin
          if (per_len[k] == 512) chk($sformatf("adc_per_period_dt%0d", dt_of(k)), adc_seen[k], 1);
          per_len[k]  = 1;
          adc_seen[k] = int'(act[1]);
        end else if (exp_act) begin
          per_len[k]++;
          adc_seen[k] += int'(act[1]);
        end else begin
          per_len[k]  = 0;
          adc_seen[k] = 0;
        end
      end
    end
  end

  task automatic wait_prd();
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (if1.prd_strb) return;
    end
    chk("prd_timeout", 0, 1);
  endtask

  // Profiles one DT=4 period; entry index i equals the counter value it decodes
  task automatic check_period(input string tag, input int chg_at, input int chg_val,
                              input int e_hs_n, input int e_hs_first, input int e_ls_n,
                              input int e_ls_first, input int e_adc_at, input int e_duty);
    int hs_n = 0, hs_first = -1, ls_n = 0, ls_first = -1, adc_n = 0, adc_at = -1, duty = -1;
    wait_prd();
    for (int i = 0; i < 512; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) duty = int'(if1.duty_o);
      if (if1.pwm_hs) begin hs_n++; if (hs_first < 0) hs_first = i; end
      if (if1.pwm_ls) begin ls_n++; if (ls_first < 0) ls_first = i; end
      if (if1.adc_trig) begin adc_n++; adc_at = i; end
      if (i == chg_at) d_comp = 9'(chg_val);
    end
    chk({tag, "_hs_n"}, hs_n, e_hs_n);
    chk({tag, "_hs_first"}, hs_first, e_hs_first);
    chk({tag, "_ls_n"}, ls_n, e_ls_n);
    chk({tag, "_ls_first"}, ls_first, e_ls_first);
    chk({tag, "_adc_n"}, adc_n, 1);
    chk({tag, "_adc_at"}, adc_at, e_adc_at);
    chk({tag, "_duty"}, duty, e_duty);
  endtask

  task automatic run_case(input string tag, input int d, input int e_hs_n, input int e_hs_first,
                          input int e_ls_n, input int e_ls_first, input int e_adc_at, input int e_duty);
    d_comp = 9'(d);
    check_period({tag, "_skip"}, -1, 0, e_hs_n, e_hs_first, e_ls_n, e_ls_first, e_adc_at, e_duty);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; d_comp = 9'd300;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'({if1.pwm_hs, if1.pwm_ls, if1.adc_trig, if1.prd_strb}), 0);
    chk("reset_duty", int'(if1.duty_o), 0);

    rst = 1'b0; d_comp = 9'd256;
    repeat (2) @(negedge clk);
    en = 1'b1;
    check_period("nominal", -1, 0, 252, 4, 252, 260, 128, 256);

    // new command takes one full period to reach the active register
    d_comp = 9'd500;
    check_period("clamp500_prev", -1, 0, 252, 4, 252, 260, 128, 256);
    check_period("clamp500", -1, 0, 482, 4, 22, 490, 243, 486);
    run_case("clamp511_a", 511, 482, 4, 22, 490, 243, 486);
    check_period("clamp511", -1, 0, 482, 4, 22, 490, 243, 486);
    run_case("duty2_a", 2, 482, 4, 22, 490, 243, 486);
    check_period("duty2", -1, 0, 0, -1, 506, 6, 1, 2);
    run_case("duty0_a", 0, 0, -1, 506, 6, 1, 2);
    check_period("duty0", -1, 0, 0, -1, 508, 4, 0, 0);
    run_case("mid_a", 256, 0, -1, 508, 4, 0, 0);
    check_period("mid_cur", 100, 128, 252, 4, 252, 260, 128, 256);
    check_period("mid_next", -1, 0, 124, 4, 380, 132, 64, 128);

    wait_prd();
    repeat (299) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("disable_outs", int'({if1.pwm_hs, if1.pwm_ls, if1.adc_trig, if1.prd_strb}), 0);
    chk("disable_duty", int'(if1.duty_o), 128);
    en = 1'b1;
    @(negedge clk);
    chk("reenable_prd", int'(if1.prd_strb), 1);

    wait_prd();
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", int'({if1.pwm_hs, if1.pwm_ls, if1.adc_trig, if1.prd_strb}), 0);
    chk("midrst_duty", int'(if1.duty_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_prd", int'(if1.prd_strb), 1);
    chk("postrst_duty", int'(if1.duty_o), 0);

    for (int seg = 0; seg < 6; seg++) begin
      int len;
      len = $urandom_range(600, 1400);
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        d_comp = 9'($urandom_range(0, 511));
      end
      if (seg % 2 == 0) en = 1'b0; else rst = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    rst = 1'b0; en = 1'b1;
    repeat (600) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dpwm_gen.md
DPWM_GEN -- requirements
Module: dpwm_gen

Interface
REQ-001 Parameter: DT, 4, dead-time in clk cycles between complementary edges (range 0..15).
REQ-002 Parameter: DUTY_MAX, 486, upper clamp on the applied duty count (approximately 0.95 of the 512-cycle period).
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  modulator enable; low forces idle.
REQ-006 Port: d_comp  input  9  unsigned duty command from the compensator, in counts of the 512-cycle period.
REQ-007 Port: pwm_hs  output  1  high-side gate drive, registered.
REQ-008 Port: pwm_ls  output  1  low-side gate drive, registered, complementary to pwm_hs with dead-time.
REQ-009 Port: adc_trig  output  1  one-cycle error-ADC sample strobe at mid on-time, registered.
REQ-010 Port: prd_strb  output  1  one-cycle period-start strobe, which clocks the compensator update, registered.
REQ-011 Port: duty_o  output  9  duty count currently applied (the active register).

Function
REQ-012 Counter: cnt SHALL be a 9-bit free-running up-counter (period fixed at 512 clk) that increments by 1 each cycle when en=1 and wraps from 511 to 0.
REQ-013 Duty load: on the edge where cnt==511 and en=1, duty_act SHALL load min(d_comp, DUTY_MAX).
- d_comp changes at any other time SHALL have no effect within the current period.
REQ-014 Output latency: outputs SHALL be registered, one cycle after the cnt value they decode; each is a function of (cnt, duty_act) sampled on the same edge.
REQ-015 High side: pwm_hs SHALL be 1 iff DT <= cnt < duty_act.
- Never asserted when duty_act <= DT.
REQ-016 Low side: pwm_ls SHALL be 1 iff duty_act+DT <= cnt <= 511, with the sum computed at 10 bits.
- Never asserted when duty_act+DT > 511.
REQ-017 Overlap: pwm_hs and pwm_ls SHALL never be 1 in the same cycle, for any inputs including DT=0 (in which case pwm_ls = !pwm_hs while en=1).
REQ-018 Dead-time at wrap: cnt 0..DT-1 SHALL give both gate outputs low, providing the ls-to-hs dead-time.
REQ-019 ADC trigger: adc_trig SHALL pulse for exactly one cycle per period, when cnt == duty_act>>1 (cnt==0 when duty_act<2).
REQ-020 Period strobe: prd_strb SHALL pulse for one cycle when cnt==0 while en=1.
REQ-021 Disable: while en=0:
- cnt SHALL be held at 0;
- pwm_hs, pwm_ls, adc_trig and prd_strb SHALL be 0 on the next edge;
- duty_act SHALL load min(d_comp, DUTY_MAX) every cycle.
REQ-022 Enable: on the first edge with en=1 after en=0, the period SHALL start at cnt==0.
- prd_strb and that period's outputs follow REQ-014 from the next edge onward.
REQ-023 Output port: duty_o SHALL equal duty_act at all times.

Reset
REQ-024 When rst=1 at an edge, cnt, duty_act, pwm_hs, pwm_ls, adc_trig and prd_strb SHALL all be 0, with rst taking priority over en and d_comp.
REQ-025 Reset mid-period SHALL abort the period with no partial pulse.
- After rst falls, operation SHALL resume per REQ-021/REQ-022.
- The first period SHALL use duty_act=0 unless en was low for at least one cycle first.

Verification
REQ-026 Nominal: en=1, d_comp=256, DT=4 -> pwm_hs high for cnt 4..255 (252 clk), pwm_ls high for cnt 260..511 (252 clk), adc_trig at cnt 128, prd_strb at cnt 0.
REQ-027 Clamp: d_comp=500 -> duty_o=486, pwm_hs for cnt 4..485, pwm_ls for cnt 490..511 (22 clk); d_comp=511 gives an identical result.
REQ-028 Small duty: d_comp=2 -> pwm_hs never high, pwm_ls for cnt 6..511, adc_trig at cnt 1; d_comp=0 gives pwm_ls for cnt 4..511 and adc_trig at cnt 0.
REQ-029 Mid-period update: d_comp moves 256 -> 128 at cnt=100 -> current period unchanged; next period pwm_hs for cnt 4..127, adc_trig at cnt 64.
REQ-030 Disable and reset mid-period: en=0 at cnt=300 -> all strobes and gates 0 on the next edge, cnt=0; rst=1 at cnt=50 -> identical result, and duty_o=0.
REQ-031 Assertions over random d_comp, en and rst, for DT in {0, 4, 15}, checked on every cycle:
- never pwm_hs && pwm_ls;
- exactly one adc_trig and one prd_strb per full enabled period;
- duty_o <= DUTY_MAX.
